// File: rtl/alu_task_pkg.sv
// Shared opcode constants and dispatcher state encoding for the arithmetic task path.
// Reused by the task FSM and its bench.
package alu_task_pkg;

    localparam logic [1:0] OP_MUL  = 2'd0;
    localparam logic [1:0] OP_ADD  = 2'd1;
    localparam logic [1:0] OP_SUB  = 2'd2;
    localparam logic [1:0] OP_RSVD = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_POP   = 2'd3
    } disp_state_e;

endpackage

// File: rtl/task_dispatcher_fifo.sv
// Synchronous command FIFO with extra-MSB pointers; head entry is visible combinationally.
// full_nxt gives the full flag as it will be after this edge, for registered ready generation.
module cmd_fifo #(
    parameter int unsigned DW    = 18,
    parameter int unsigned DEPTH = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic          pop,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] dout,
    output logic          full,
    output logic          empty,
    output logic          full_nxt
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [DW-1:0] mem [DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic [AW:0]   wr_nxt;
    logic [AW:0]   rd_nxt;
    logic          do_push;
    logic          do_pop;

    function automatic logic is_full(input logic [AW:0] w, input logic [AW:0] r);
        return (w[AW] != r[AW]) && (w[AW-1:0] == r[AW-1:0]);
    endfunction

    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign wr_nxt   = do_push ? wr_ptr + (AW+1)'(1) : wr_ptr;
    assign rd_nxt   = do_pop  ? rd_ptr + (AW+1)'(1) : rd_ptr;
    assign empty    = (wr_ptr == rd_ptr);
    assign full     = is_full(wr_ptr, rd_ptr);
    assign full_nxt = is_full(wr_nxt, rd_nxt);
    assign dout     = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            wr_ptr <= wr_nxt;
            rd_ptr <= rd_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= din;
        end
    end

endmodule

// File: rtl/task_dispatcher.sv
// Buffers arithmetic commands and issues them one at a time to the task FSM,
// holding each until done or timeout; counts completions and flags errors.
module task_dispatcher
    import alu_task_pkg::*;
#(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_opcode,
    input  logic [WIDTH-1:0] cmd_a,
    input  logic [WIDTH-1:0] cmd_b,
    output logic             task_valid,
    output logic [1:0]       task_opcode,
    output logic [WIDTH-1:0] task_a,
    output logic [WIDTH-1:0] task_b,
    input  logic             task_done,
    output logic             busy,
    output logic [15:0]      done_count,
    output logic             err_bad_op,
    output logic             err_timeout
);

    localparam int unsigned DW = 2 + 2 * WIDTH;
    localparam int unsigned TW = $clog2(TIMEOUT);
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

    disp_state_e   state;
    disp_state_e   state_nxt;
    logic [TW-1:0] timer;
    logic          xfer;
    logic          push;
    logic          bad;
    logic          pop;
    logic          load;
    logic          done_seen;
    logic          counted;
    logic          fifo_full;
    logic          fifo_empty;
    logic          fifo_full_nxt;
    logic [DW-1:0] fifo_din;
    logic [DW-1:0] fifo_head;

    assign xfer     = cmd_valid && cmd_ready;
    assign push     = xfer && (cmd_opcode != OP_RSVD);
    assign bad      = xfer && (cmd_opcode == OP_RSVD);
    assign fifo_din = {cmd_opcode, cmd_a, cmd_b};
    assign busy     = !fifo_empty || (state != ST_IDLE);

    cmd_fifo #(
        .DW    (DW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (push),
        .pop      (pop),
        .din      (fifo_din),
        .dout     (fifo_head),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .full_nxt (fifo_full_nxt)
    );

    // err_timeout is decoded in the last WAIT cycle so done arriving in that same cycle can suppress it
    always_comb begin
        state_nxt   = state;
        task_valid  = 1'b0;
        err_timeout = 1'b0;
        pop         = 1'b0;
        load        = 1'b0;
        done_seen   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    state_nxt = ST_ISSUE;
                    load      = 1'b1;
                end
            end
            ST_ISSUE: begin
                task_valid = 1'b1;
                if (task_done) begin
                    state_nxt = ST_POP;
                    done_seen = 1'b1;
                end else begin
                    state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (task_done) begin
                    state_nxt = ST_POP;
                    done_seen = 1'b1;
                end else if (timer == T_LAST) begin
                    state_nxt   = ST_POP;
                    err_timeout = 1'b1;
                end
            end
            ST_POP: begin
                pop       = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            timer       <= '0;
            counted     <= 1'b0;
            done_count  <= '0;
            cmd_ready   <= 1'b0;
            err_bad_op  <= 1'b0;
            task_opcode <= '0;
            task_a      <= '0;
            task_b      <= '0;
        end else begin
            state      <= state_nxt;
            counted    <= done_seen;
            cmd_ready  <= !fifo_full_nxt;
            err_bad_op <= bad;
            if (state == ST_ISSUE) begin
                timer <= '0;
            end else if (state == ST_WAIT) begin
                timer <= timer + TW'(1);
            end
            if (load) begin
                {task_opcode, task_a, task_b} <= fifo_head;
            end
            if ((state == ST_POP) && counted) begin
                done_count <= done_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_task_dispatcher.sv
// Directed bench for task_dispatcher: vector table for single commands plus
// hand-written sequences for FIFO backpressure, ordering and mid-task reset.
module tb_task_dispatcher;

    localparam int unsigned TO = 16;

    logic       clk = 1'b0;
    logic       reset;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_opcode;
    logic [7:0] cmd_a;
    logic [7:0] cmd_b;
    logic       task_valid;
    logic [1:0] task_opcode;
    logic [7:0] task_a;
    logic [7:0] task_b;
    logic       task_done;
    logic       busy;
    logic [15:0] done_count;
    logic       err_bad_op;
    logic       err_timeout;

    task_dispatcher #(
        .WIDTH   (8),
        .DEPTH   (4),
        .TIMEOUT (TO)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_opcode  (cmd_opcode),
        .cmd_a       (cmd_a),
        .cmd_b       (cmd_b),
        .task_valid  (task_valid),
        .task_opcode (task_opcode),
        .task_a      (task_a),
        .task_b      (task_b),
        .task_done   (task_done),
        .busy        (busy),
        .done_count  (done_count),
        .err_bad_op  (err_bad_op),
        .err_timeout (err_timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [7:0]  dly;
        logic        exp_valid;
        logic        exp_bad;
        logic        exp_tmo;
        logic [15:0] exp_cnt;
    } vec_t;

    int n_tests = 0;
    int n_fail  = 0;
    int n_tmo   = 0;
    logic [7:0] issued[$];

    // Issue log and timeout pulses, sampled mid-cycle
    always @(negedge clk) begin
        if (task_valid) issued.push_back(task_a);
        if (err_timeout) n_tmo++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, ".cmd_ready"},   cmd_ready,   0);
        check({tag, ".task_valid"},  task_valid,  0);
        check({tag, ".task_opcode"}, task_opcode, 0);
        check({tag, ".task_a"},      task_a,      0);
        check({tag, ".task_b"},      task_b,      0);
        check({tag, ".busy"},        busy,        0);
        check({tag, ".done_count"},  done_count,  0);
        check({tag, ".err_bad_op"},  err_bad_op,  0);
        check({tag, ".err_timeout"}, err_timeout, 0);
    endtask

    task automatic wait_ready();
        int w = 0;
        while (!cmd_ready && w < 50) begin
            tick();
            w++;
        end
        if (w >= 50) check("ready_wait_expired", cmd_ready, 1);
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int   tmo_at;
        logic ended;
        int   isz;
        wait_ready();
        cmd_valid  = 1'b1;
        cmd_opcode = v.op;
        cmd_a      = v.a;
        cmd_b      = v.b;
        tick();
        cmd_valid = 1'b0;
        check({tag, ".bad_op"}, err_bad_op, v.exp_bad);
        check({tag, ".no_early_valid"}, task_valid, 0);
        isz = issued.size();
        tick();
        check({tag, ".task_valid"}, task_valid, v.exp_valid);
        if (v.exp_valid) begin
            check({tag, ".task_opcode"}, task_opcode, v.op);
            check({tag, ".task_a"}, task_a, v.a);
            check({tag, ".task_b"}, task_b, v.b);
            tmo_at = -1;
            ended  = 1'b0;
            for (int k = 0; k <= int'(TO) + 4; k++) begin
                task_done = (k == int'(v.dly));
                #1;
                if (k == 1) check({tag, ".valid_one_cycle"}, task_valid, 0);
                if (err_timeout) tmo_at = k;
                ended = task_done || err_timeout;
                if (ended) check({tag, ".hold_a"}, task_a, v.a);
                tick();
                task_done = 1'b0;
                if (ended) break;
            end
            check({tag, ".task_ended"}, ended, 1);
            tick();
            check({tag, ".timeout_seen"}, (tmo_at >= 0), v.exp_tmo);
            if (v.exp_tmo) check({tag, ".timeout_cycle"}, tmo_at, TO);
        end else begin
            check({tag, ".bad_op_one_cycle"}, err_bad_op, 0);
            repeat (3) tick();
            check({tag, ".no_issue"}, issued.size(), isz);
        end
        check({tag, ".done_count"}, done_count, v.exp_cnt);
        check({tag, ".busy"}, busy, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    initial begin
        vec_t vecs [7];
        vec_t post;
        int   base;
        int   tmo0;
        logic got;
        logic [15:0] cnt0;

        //           op     a       b       dly    valid bad   tmo   count
        vecs[0] = '{2'd1, 8'd5,   8'd3,   8'd4,   1'b1, 1'b0, 1'b0, 16'd1};
        vecs[1] = '{2'd0, 8'd12,  8'd10,  8'd0,   1'b1, 1'b0, 1'b0, 16'd2};
        vecs[2] = '{2'd2, 8'd200, 8'd55,  8'd1,   1'b1, 1'b0, 1'b0, 16'd3};
        vecs[3] = '{2'd3, 8'd1,   8'd2,   8'd0,   1'b0, 1'b1, 1'b0, 16'd3};
        vecs[4] = '{2'd1, 8'd255, 8'd1,   8'hFF,  1'b1, 1'b0, 1'b1, 16'd3};
        vecs[5] = '{2'd0, 8'd7,   8'd9,   8'd16,  1'b1, 1'b0, 1'b0, 16'd4};
        vecs[6] = '{2'd2, 8'd0,   8'd255, 8'd15,  1'b1, 1'b0, 1'b0, 16'd5};
        post    = '{2'd1, 8'd99,  8'd66,  8'd2,   1'b1, 1'b0, 1'b0, 16'd1};

        reset      = 1'b1;
        cmd_valid  = 1'b0;
        cmd_opcode = '0;
        cmd_a      = '0;
        cmd_b      = '0;
        task_done  = 1'b0;
        repeat (3) tick();
        check_zero("reset");
        reset = 1'b0;

        for (int i = 0; i < 7; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // task_done while idle must not count
        base      = issued.size();
        task_done = 1'b1;
        tick();
        task_done = 1'b0;
        repeat (3) tick();
        check("idle_done.count", done_count, 5);
        check("idle_done.busy", busy, 0);
        check("idle_done.no_issue", issued.size(), base);

        // Fill the FIFO while the first task hangs; fifth command waits for the pop
        base = issued.size();
        tmo0 = n_tmo;
        cnt0 = done_count;
        cmd_opcode = 2'd1;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("fill.ready%0d", i), cmd_ready, 1);
            cmd_valid = 1'b1;
            cmd_a     = 8'(20 + i);
            cmd_b     = 8'(i);
            tick();
        end
        cmd_a = 8'd24;
        cmd_b = 8'd4;
        check("fill.ready_full", cmd_ready, 0);
        got = 1'b0;
        for (int w = 0; w < int'(TO) + 10; w++) begin
            if (cmd_ready) begin
                got = 1'b1;
                break;
            end
            tick();
        end
        check("fill.fifth_accepted", got, 1);
        tick();
        cmd_valid = 1'b0;
        for (int c = 0; c < 80; c++) begin
            task_done = task_valid;
            tick();
            task_done = 1'b0;
            if (issued.size() >= base + 5 && !busy) break;
        end
        check("fill.issue_count", issued.size(), base + 5);
        for (int i = 0; i < 5; i++) begin
            if (issued.size() > base + i)
                check($sformatf("fill.order%0d", i), issued[base + i], 20 + i);
        end
        check("fill.timeouts", n_tmo - tmo0, 1);
        check("fill.done_count", done_count, cnt0 + 16'd4);
        check("fill.busy", busy, 0);

        // Reset while in WAIT with two commands still queued
        cmd_opcode = 2'd2;
        for (int i = 0; i < 3; i++) begin
            cmd_valid = 1'b1;
            cmd_a     = 8'(40 + i);
            cmd_b     = 8'(i);
            tick();
        end
        cmd_valid = 1'b0;
        tick();
        check("midreset.busy_before", busy, 1);
        reset = 1'b1;
        #1;
        check_zero("midreset");
        tick();
        reset = 1'b0;
        base  = issued.size();
        repeat (10) tick();
        check("midreset.no_issue", issued.size(), base);
        check("midreset.busy_after", busy, 0);
        check("midreset.ready_after", cmd_ready, 1);

        run_vec(post, "post_reset");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
